// File: rtl/ch_dispatcher_pkg.sv
// Types shared by the channel dispatcher and the benches that observe it.
package ch_dispatcher_pkg;

  typedef enum logic {
    SELECT = 1'b0,
    LOAD   = 1'b1
  } disp_state_e;

endpackage

// File: rtl/math_pkg.sv
// Shared arithmetic helpers for elaboration-time width calculations.
package math_pkg;

  // Ceiling log2, never less than 1 so every derived vector has a legal width.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_free_arbiter.sv
// Combinational round-robin search for the first non-busy channel at or after ptr.
module rr_free_arbiter
  import math_pkg::*;
#(
  parameter int N_CHS = 4,
  parameter int PW    = log2(N_CHS)
) (
  input  logic [N_CHS-1:0] busy,
  input  logic [PW-1:0]    ptr,
  output logic             found,
  output logic [PW-1:0]    idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_CHS; i++) begin
      int c;
      // ptr is always below N_CHS, so a single modulo keeps non-power-of-two counts in range
      c = (int'(ptr) + i) % N_CHS;
      if (!found && !busy[c]) begin
        found = 1'b1;
        idx   = PW'(c);
      end
    end
  end

endmodule

// File: rtl/ch_dispatcher.sv
// Assigns whole fixed-length frames to free decoder channels round-robin and drives the demux.
module ch_dispatcher
  import math_pkg::*;
  import ch_dispatcher_pkg::*;
#(
  parameter int N_CHS      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 256
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [N_CHS-1:0]       i_ch_done,
  output logic [log2(N_CHS)-1:0] o_mux_s,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic [N_CHS-1:0]       o_ch_we,
  output logic [N_CHS-1:0]       o_ch_sof,
  output logic [N_CHS-1:0]       o_busy,
  output logic                   o_err
);

  localparam int PW = log2(N_CHS);
  localparam int CW = log2(FRAME_LEN);
  localparam logic [PW-1:0] LAST_CH   = PW'(N_CHS - 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(FRAME_LEN - 1);
  localparam logic [N_CHS-1:0] ONE_CH = N_CHS'(1);

  disp_state_e state, next_state;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    cur;
  logic [CW-1:0]    cnt;
  logic [N_CHS-1:0] busy;
  logic [N_CHS-1:0] busy_set;
  logic             err;
  logic             sel_found;
  logic [PW-1:0]    sel_idx;
  logic             accept;
  logic             last_word;
  logic             we_s1;
  logic             sof_s1;

  rr_free_arbiter #(
    .N_CHS (N_CHS),
    .PW    (PW)
  ) u_arb (
    .busy  (busy),
    .ptr   (ptr),
    .found (sel_found),
    .idx   (sel_idx)
  );

  assign accept    = (state == LOAD) && i_valid;
  assign last_word = accept && (cnt == LAST_WORD);
  assign busy_set  = last_word ? (ONE_CH << cur) : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= SELECT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      SELECT:  if (sel_found) next_state = LOAD;
      LOAD:    if (last_word) next_state = SELECT;
      default: next_state = SELECT;
    endcase
  end

  always_comb begin
    o_ready = (state == LOAD);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr <= '0;
      cur <= '0;
      cnt <= '0;
    end else if ((state == SELECT) && sel_found) begin
      cur <= sel_idx;
      ptr <= (sel_idx == LAST_CH) ? '0 : sel_idx + 1'b1;
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A set on the final word wins over a same-cycle done; that done is still flagged as an error
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= (busy & ~i_ch_done) | busy_set;
      err  <= err | (|(i_ch_done & ~busy));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data  <= '0;
      o_mux_s <= '0;
      we_s1   <= 1'b0;
      sof_s1  <= 1'b0;
    end else begin
      o_data <= accept ? i_data : '0;
      if (accept) o_mux_s <= cur;
      we_s1  <= accept;
      sof_s1 <= accept && (cnt == '0);
    end
  end

  // Strobes lag the data by one cycle to line up with the demux's own output register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ch_we  <= '0;
      o_ch_sof <= '0;
    end else begin
      o_ch_we  <= we_s1  ? (ONE_CH << o_mux_s) : '0;
      o_ch_sof <= sof_s1 ? (ONE_CH << o_mux_s) : '0;
    end
  end

  assign o_busy = busy;
  assign o_err  = err;

endmodule

// File: tb/tb_ch_dispatcher.sv
// Scoreboard bench for ch_dispatcher: 4-channel main instance plus a 3-channel instance.
module tb_ch_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic [3:0]  ch_done;
  logic [1:0]  mux_s;
  logic [31:0] odata;
  logic [3:0]  ch_we;
  logic [3:0]  ch_sof;
  logic [3:0]  busy;
  logic        err;

  logic [31:0] data2;
  logic        valid2;
  logic        ready2;
  logic [2:0]  ch_done2;
  logic [1:0]  mux_s2;
  logic [31:0] odata2;
  logic [2:0]  ch_we2;
  logic [2:0]  ch_sof2;
  logic [2:0]  busy2;
  logic        err2;

  always #5 clk = ~clk;

  ch_dispatcher #(.N_CHS(4), .DATA_WIDTH(32), .FRAME_LEN(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid), .o_ready(ready),
    .i_ch_done(ch_done), .o_mux_s(mux_s), .o_data(odata), .o_ch_we(ch_we),
    .o_ch_sof(ch_sof), .o_busy(busy), .o_err(err)
  );

  ch_dispatcher #(.N_CHS(3), .DATA_WIDTH(32), .FRAME_LEN(8)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_data(data2), .i_valid(valid2), .o_ready(ready2),
    .i_ch_done(ch_done2), .o_mux_s(mux_s2), .o_data(odata2), .o_ch_we(ch_we2),
    .o_ch_sof(ch_sof2), .o_busy(busy2), .o_err(err2)
  );

  typedef struct {
    int          ch;
    logic [31:0] data;
    bit          sof;
  } exp_t;

  typedef struct {
    int         base;
    int         gap;
    int         ch;
    logic [3:0] busy_after;
  } vec_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt[4];
  int          we_total = 0;
  logic [31:0] data_prev = '0;
  bit          mon_en = 1'b0;
  int          sof_log[$];
  int          we2_cnt = 0;
  bit          mux_bad = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Demux-side monitor: every write strobe must match the oldest outstanding scoreboard entry
  always @(negedge clk) begin
    if (mon_en) begin
      if (ch_we != 4'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_we", {60'b0, ch_we}, 64'h0);
        end else begin
          exp_t e;
          logic [3:0] oh;
          e  = sb.pop_front();
          oh = 4'b0001 << e.ch;
          chk("we_channel", {60'b0, ch_we}, {60'b0, oh});
          chk("sof_flag", {60'b0, ch_sof}, e.sof ? {60'b0, oh} : 64'h0);
          chk("word_data", {32'b0, data_prev}, {32'b0, e.data});
        end
        for (int k = 0; k < 4; k++) if (ch_we[k]) we_cnt[k]++;
        we_total++;
      end else begin
        chk("gap_data_zero", {32'b0, data_prev}, 64'h0);
      end
    end
    data_prev = odata;
  end

  always @(negedge clk) begin
    if (ch_sof2 != 3'b0) begin
      for (int k = 0; k < 3; k++) if (ch_sof2[k]) sof_log.push_back(k);
    end
    for (int k = 0; k < 3; k++) if (ch_we2[k]) we2_cnt++;
    if (mux_s2 == 2'd3) mux_bad = 1'b1;
  end

  task automatic send(input int base, input int n, input int gap_pct, input int ch);
    int w;
    int budget;
    w = 0;
    budget = 0;
    while (w < n && budget < 400) begin
      @(negedge clk);
      budget++;
      valid = ($urandom_range(99) >= gap_pct);
      data  = base + w;
      if (valid && ready) begin
        sb.push_back('{ch, 32'(base + w), (w == 0)});
        w++;
      end
    end
    @(negedge clk);
    valid = 1'b0;
    data  = '0;
    if (w < n) chk("send_timeout", 64'(w), 64'(n));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vec_t vecs[4];
    int   exp_seq[4];
    int   budget;
    bit   ready_seen;
    int   we_before;

    vecs[0] = '{1,  0,  0, 4'b0001};
    vecs[1] = '{9,  0,  1, 4'b0011};
    vecs[2] = '{17, 0,  2, 4'b0111};
    vecs[3] = '{25, 50, 3, 4'b1111};
    exp_seq = '{0, 1, 2, 0};

    rst = 1'b1; data = '0; valid = 1'b0; ch_done = '0;
    data2 = '0; valid2 = 1'b0; ch_done2 = '0;
    for (int k = 0; k < 4; k++) we_cnt[k] = 0;
    idle(3);
    chk("rst_ready", {63'b0, ready}, 64'h0);
    chk("rst_busy", {60'b0, busy}, 64'h0);
    chk("rst_err", {63'b0, err}, 64'h0);
    chk("rst_we", {60'b0, ch_we}, 64'h0);
    chk("rst_data", {32'b0, odata}, 64'h0);
    chk("rst_mux", {62'b0, mux_s}, 64'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Four frames into an empty dispatcher, the last one with random valid gaps
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].base, 8, vecs[i].gap, vecs[i].ch);
      idle(3);
      chk("busy_after_frame", {60'b0, busy}, {60'b0, vecs[i].busy_after});
    end
    for (int k = 0; k < 4; k++) chk("we_per_channel", 64'(we_cnt[k]), 64'd8);

    // All channels busy: offered data must be held off
    ready_seen = 1'b0;
    valid = 1'b1;
    data  = 32'd33;
    repeat (20) begin
      @(negedge clk);
      if (ready) ready_seen = 1'b1;
    end
    valid = 1'b0;
    chk("all_busy_backpressure", {63'b0, ready_seen}, 64'h0);
    @(negedge clk) ch_done = 4'b0100;
    @(negedge clk) ch_done = 4'b0000;
    chk("done2_clears", {60'b0, busy}, {60'b0, 4'b1011});
    send(33, 8, 0, 2);
    idle(3);
    chk("ch2_refilled", {60'b0, busy}, {60'b0, 4'b1111});
    chk("err_still_clear", {63'b0, err}, 64'h0);

    // Simultaneous dones, then a spurious done on an idle channel
    @(negedge clk) ch_done = 4'b0011;
    @(negedge clk) ch_done = 4'b0000;
    chk("multi_done", {60'b0, busy}, {60'b0, 4'b1100});
    chk("multi_done_no_err", {63'b0, err}, 64'h0);
    @(negedge clk) ch_done = 4'b0010;
    @(negedge clk) ch_done = 4'b0000;
    chk("spurious_done_err", {63'b0, err}, 64'h1);
    chk("spurious_done_busy", {60'b0, busy}, {60'b0, 4'b1100});
    send(41, 8, 0, 0);
    idle(3);
    chk("wrap_to_ch0", {60'b0, busy}, {60'b0, 4'b1101});
    chk("err_sticky", {63'b0, err}, 64'h1);

    // Reset in the middle of a frame destined for ch1
    send(200, 3, 0, 1);
    idle(3);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    we_before = we_total;
    chk("midrst_busy", {60'b0, busy}, 64'h0);
    chk("midrst_err", {63'b0, err}, 64'h0);
    idle(10);
    chk("no_we_after_rst", 64'(we_total - we_before), 64'h0);
    send(300, 8, 30, 0);
    idle(3);
    chk("post_rst_ch0", {60'b0, busy}, {60'b0, 4'b0001});

    budget = 0;
    while (sb.size() != 0 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'h0);

    // Three-channel instance: pointer must wrap at 3, not at 4
    valid2 = 1'b1;
    budget = 0;
    while (busy2 != 3'b111 && budget < 200) begin
      @(negedge clk);
      data2 = data2 + 1;
      budget++;
    end
    chk("n3_all_busy", {61'b0, busy2}, {61'b0, 3'b111});
    @(negedge clk) ch_done2 = 3'b001;
    @(negedge clk) ch_done2 = 3'b000;
    budget = 0;
    while (!(sof_log.size() >= 4 && busy2 == 3'b111) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    valid2 = 1'b0;
    idle(4);
    chk("n3_frame_count", 64'(sof_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < sof_log.size()) chk("n3_channel_order", 64'(sof_log[i]), 64'(exp_seq[i]));
      else chk("n3_channel_order", 64'hFFFF, 64'(exp_seq[i]));
    end
    chk("n3_we_total", 64'(we2_cnt), 64'd32);
    chk("n3_no_select_3", {63'b0, mux_bad}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
